// File: rtl/sa_cache_pkg.sv
// Shared cache definitions: address split, miss-controller states
// and a saturating statistics increment.
package sa_cache_pkg;

  localparam int TAG_W = 18;
  localparam int IDX_W = 8;
  localparam int OFF_W = 6;
  localparam int ADDR_W_DEF = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESPOND,
    ERROR
  } state_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sa_cache_req_timer.sv
// Memory request wait timer; flags the cycle in which the
// TIMEOUT-th consecutive un-acked request cycle occurs.
module sa_cache_req_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = count && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sa_cache_miss_ctrl.sv
// Cache miss controller: optional dirty-victim writeback, line
// refill, single-cycle response, request timeout and statistics.
module sa_cache_miss_ctrl
  import sa_cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cache_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              i_evict,
  input  logic [ADDR_W-1:0] i_evict_addr,
  input  logic [DATA_W-1:0] i_evict_data,
  output logic [DATA_W-1:0] o_memory_line,
  output logic              o_memory_response,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_error,
  output logic [15:0]       o_miss_cnt,
  output logic [15:0]       o_wb_cnt
);

  localparam int LINE_W = ADDR_W - OFF_W;

  state_t              state;
  state_t              state_n;
  logic                armed;
  logic [LINE_W-1:0]   m_line;
  logic [ADDR_W-1:0]   ev_addr;
  logic [DATA_W-1:0]   ev_data;
  logic                accept;
  logic                wb_ack;
  logic                rf_ack;
  logic                t_clear;
  logic                t_count;
  logic                t_expired;

  assign accept = (state == IDLE) && i_cache_miss && armed;
  assign wb_ack = (state == WRITEBACK) && i_mem_ack;
  assign rf_ack = (state == REFILL) && i_mem_ack;

  assign t_clear = (state == IDLE) || wb_ack;
  assign t_count = o_mem_req && !i_mem_ack;

  sa_cache_req_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (t_clear),
    .count  (t_count),
    .expired(t_expired)
  );

  always_comb begin
    state_n     = state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = i_evict ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = ev_addr;
        o_mem_wdata = ev_data;
        if (i_mem_ack) begin
          state_n = REFILL;
        end else if (t_expired) begin
          state_n = ERROR;
        end
      end
      REFILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = {m_line, {OFF_W{1'b0}}};
        if (i_mem_ack) begin
          state_n = RESPOND;
        end else if (t_expired) begin
          state_n = ERROR;
        end
      end
      RESPOND: state_n = IDLE;
      ERROR:   state_n = ERROR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      armed             <= 1'b1;
      m_line            <= '0;
      ev_addr           <= '0;
      ev_data           <= '0;
      o_memory_line     <= '0;
      o_memory_response <= 1'b0;
      o_busy            <= 1'b0;
      o_error           <= 1'b0;
      o_miss_cnt        <= '0;
      o_wb_cnt          <= '0;
    end else begin
      state             <= state_n;
      o_memory_response <= (state_n == RESPOND);
      o_busy            <= (state_n != IDLE);
      o_error           <= (state_n == ERROR);
      // re-arm only once the miss line has been seen low
      if (!i_cache_miss) begin
        armed <= 1'b1;
      end else if (accept) begin
        armed <= 1'b0;
      end
      if (accept) begin
        m_line  <= i_miss_addr[ADDR_W-1:OFF_W];
        ev_addr <= i_evict_addr;
        ev_data <= i_evict_data;
      end
      if (rf_ack) begin
        o_memory_line <= i_mem_rdata;
        o_miss_cnt    <= sat_inc(o_miss_cnt);
      end
      if (wb_ack) begin
        o_wb_cnt <= sat_inc(o_wb_cnt);
      end
    end
  end

endmodule

// File: tb/tb_sa_cache_miss_ctrl.sv
// Directed scoreboard bench for the cache miss controller.
module tb_sa_cache_miss_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  logic        clk;
  logic        rst;
  logic        miss;
  logic [31:0] maddr;
  logic        evict;
  logic [31:0] eaddr;
  logic [31:0] edata;
  logic [31:0] line;
  logic        resp;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;
  logic [15:0] miss_cnt;
  logic [15:0] wb_cnt;

  int n_vec;
  int n_err;
  int exp_miss;
  int exp_wb;

  req_t        req_q[$];
  logic [31:0] resp_q[$];

  sa_cache_miss_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_cache_miss     (miss),
    .i_miss_addr      (maddr),
    .i_evict          (evict),
    .i_evict_addr     (eaddr),
    .i_evict_data     (edata),
    .o_memory_line    (line),
    .o_memory_response(resp),
    .o_mem_req        (req),
    .o_mem_we         (we),
    .o_mem_addr       (addr),
    .o_mem_wdata      (wdata),
    .i_mem_ack        (ack),
    .i_mem_rdata      (rdata),
    .o_busy           (busy),
    .o_error          (err),
    .o_miss_cnt       (miss_cnt),
    .o_wb_cnt         (wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic mem_serve(
    input int          delay,
    input logic [31:0] rd
  );
    req_t e;
    int   k;
    k = 0;
    while (req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("req_seen", 64'(req), 64'd1);
    e = req_q.pop_front();
    check("req_addr", 64'(addr), 64'(e.addr));
    check("req_we", 64'(we), 64'(e.we));
    if (e.we) check("req_wdata", 64'(wdata), 64'(e.wdata));
    repeat (delay) begin
      step();
      check("req_hold", {31'd0, req, addr},
            {31'd0, 1'b1, e.addr});
    end
    ack   = 1'b1;
    rdata = rd;
    step();
    ack   = 1'b0;
    rdata = 32'h0;
  endtask

  task automatic wait_resp();
    logic [31:0] e;
    int          k;
    k = 0;
    while (resp !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check("resp_seen", 64'(resp), 64'd1);
    e = resp_q.pop_front();
    check("resp_line", 64'(line), 64'(e));
    step();
    check("resp_pulse", 64'(resp), 64'd0);
    check("line_hold", 64'(line), 64'(e));
    check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    check("wb_cnt", 64'(wb_cnt), 64'(exp_wb));
    check("busy_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int hi;
    n_vec    = 0;
    n_err    = 0;
    exp_miss = 0;
    exp_wb   = 0;
    rst   = 1'b0;
    miss  = 1'b0;
    maddr = 32'h0;
    evict = 1'b0;
    eaddr = 32'h0;
    edata = 32'h0;
    ack   = 1'b0;
    rdata = 32'h0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    check("rst_line", 64'(line), 64'd0);
    check("rst_mcnt", 64'(miss_cnt), 64'd0);
    check("rst_wcnt", 64'(wb_cnt), 64'd0);
    rst = 1'b1;
    step();
    step();

    // clean miss, ack after 3 wait cycles
    miss  = 1'b1;
    maddr = 32'h0001_2345;
    req_q.push_back('{32'h0001_2340, 1'b0, 32'h0});
    resp_q.push_back(32'hDEAD_BEEF);
    exp_miss++;
    step();
    miss = 1'b0;
    check("clean_busy", 64'(busy), 64'd1);
    mem_serve(3, 32'hDEAD_BEEF);
    wait_resp();

    // evict and ack without a miss are ignored
    evict = 1'b1;
    eaddr = 32'h0000_1111;
    repeat (3) step();
    check("evict_only_req", 64'(req), 64'd0);
    check("evict_only_busy", 64'(busy), 64'd0);
    evict = 1'b0;
    ack   = 1'b1;
    step();
    ack   = 1'b0;
    step();
    check("stray_ack_resp", 64'(resp), 64'd0);
    check("stray_ack_mcnt", 64'(miss_cnt),
          64'(exp_miss));

    // dirty miss: writeback then refill
    miss  = 1'b1;
    maddr = 32'h0ABC_DE7F;
    evict = 1'b1;
    eaddr = 32'h0000_8040;
    edata = 32'hCAFE_F00D;
    req_q.push_back('{32'h0000_8040, 1'b1, 32'hCAFE_F00D});
    req_q.push_back('{32'h0ABC_DE40, 1'b0, 32'h0});
    resp_q.push_back(32'h1234_5678);
    exp_wb++;
    exp_miss++;
    step();
    miss  = 1'b0;
    evict = 1'b0;
    eaddr = 32'h0;
    edata = 32'h0;
    mem_serve(1, 32'h0);
    check("wb_no_gap", 64'(req), 64'd1);
    mem_serve(2, 32'h1234_5678);
    wait_resp();

    // ack in first refill cycle
    miss  = 1'b1;
    maddr = 32'h0000_00FF;
    resp_q.push_back(32'hA5A5_0001);
    exp_miss++;
    step();
    miss = 1'b0;
    check("lat_addr", 64'(addr), 64'h0000_00C0);
    ack   = 1'b1;
    rdata = 32'hA5A5_0001;
    step();
    ack   = 1'b0;
    check("lat3_resp", 64'(resp), 64'd1);
    wait_resp();

    // miss held high across the response
    miss  = 1'b1;
    maddr = 32'h0F0F_0F3C;
    req_q.push_back('{32'h0F0F_0F00, 1'b0, 32'h0});
    resp_q.push_back(32'h0BAD_F00D);
    exp_miss++;
    step();
    mem_serve(0, 32'h0BAD_F00D);
    wait_resp();
    repeat (2) begin
      step();
      check("held_no_req", 64'(req), 64'd0);
      check("held_idle", 64'(busy), 64'd0);
    end
    miss = 1'b0;
    step();
    miss  = 1'b1;
    maddr = 32'h0000_1000;
    req_q.push_back('{32'h0000_1000, 1'b0, 32'h0});
    resp_q.push_back(32'h1111_2222);
    exp_miss++;
    step();
    miss = 1'b0;
    mem_serve(1, 32'h1111_2222);
    wait_resp();

    // reset in the middle of a refill
    miss  = 1'b1;
    maddr = 32'h2000_0000;
    step();
    miss = 1'b0;
    step();
    check("mid_req", 64'(req), 64'd1);
    rst = 1'b0;
    #1;
    exp_miss = 0;
    exp_wb   = 0;
    check("arst_req", 64'(req), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_mcnt", 64'(miss_cnt), 64'(exp_miss));
    check("arst_wcnt", 64'(wb_cnt), 64'(exp_wb));
    check("arst_line", 64'(line), 64'd0);
    repeat (2) begin
      step();
      check("arst_no_resp", 64'(resp), 64'd0);
    end
    rst = 1'b1;
    step();

    // request timeout into sticky error
    miss  = 1'b1;
    maddr = 32'h3000_0040;
    step();
    miss = 1'b0;
    hi   = 0;
    while (req === 1'b1 && hi < 30) begin
      hi++;
      step();
    end
    check("to_req_cycles", 64'(hi), 64'd8);
    check("to_err", 64'(err), 64'd1);
    check("to_busy", 64'(busy), 64'd1);
    miss = 1'b1;
    step();
    step();
    miss = 1'b0;
    ack  = 1'b1;
    step();
    ack  = 1'b0;
    check("err_sticky", 64'(err), 64'd1);
    check("err_no_req", 64'(req), 64'd0);
    check("err_mcnt", 64'(miss_cnt), 64'(exp_miss));
    rst = 1'b0;
    #1;
    check("err_rst", 64'(err), 64'd0);
    check("err_rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_cache_miss_ctrl.md
SA_CACHE_MISS_CTRL -- requirements
Module: sa_cache_miss_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width, equal to tag(18)+index(8)+offset(6).
REQ-002 SHALL have parameter DATA_W, default 32: line/word width, matching the cache line port.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles a memory request waits for ack.
REQ-004 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_cache_miss, input, 1: miss flag from the cache.
REQ-007 SHALL have port i_miss_addr, input, ADDR_W: {tag,index,offset} of the missing access.
REQ-008 SHALL have port i_evict, input, 1: the miss requires writeback of a dirty victim.
REQ-009 SHALL have port i_evict_addr, input, ADDR_W: victim address.
REQ-010 SHALL have port i_evict_data, input, DATA_W: victim line.
REQ-011 SHALL have port o_memory_line, output, DATA_W: refill line to the cache.
REQ-012 SHALL have port o_memory_response, output, 1: single-cycle refill-valid pulse to the cache.
REQ-013 SHALL have ports o_mem_req (1), o_mem_we (1), o_mem_addr (ADDR_W), o_mem_wdata (DATA_W), all outputs: backing-memory request.
REQ-014 SHALL have ports i_mem_ack (1) and i_mem_rdata (DATA_W), inputs: memory completion and read data.
REQ-015 SHALL have outputs o_busy (1), o_error (1), o_miss_cnt (16) and o_wb_cnt (16): status and statistics.

Function
REQ-016 SHALL implement FSM states IDLE, WRITEBACK, REFILL, RESPOND, ERROR.
REQ-017 In IDLE with i_cache_miss=1 and armed=1, SHALL latch miss/evict address and data, clear armed, and go to WRITEBACK if i_evict=1, else REFILL.
REQ-018 i_evict while i_cache_miss=0 SHALL be ignored.
REQ-019 In WRITEBACK, SHALL drive o_mem_req=1, o_mem_we=1, o_mem_addr=latched evict addr, o_mem_wdata=latched evict data.
REQ-020 In REFILL, SHALL drive o_mem_req=1, o_mem_we=0, o_mem_addr={latched tag, latched index, 6'b0}.
REQ-021 Request outputs SHALL stay stable until i_mem_ack is sampled high; ack in the first request cycle SHALL count.
REQ-022 On ack in WRITEBACK, SHALL go to REFILL next cycle; o_mem_req SHALL stay high (new address) with no idle cycle.
REQ-023 On ack in REFILL, SHALL capture i_mem_rdata into o_memory_line and go to RESPOND.
REQ-024 In RESPOND, SHALL assert o_memory_response for exactly one cycle, then return to IDLE.
REQ-025 o_memory_line SHALL hold its value until the next refill capture.
REQ-026 i_mem_ack while o_mem_req=0 SHALL be ignored.
REQ-027 armed SHALL set when i_cache_miss is sampled 0, so one miss produces exactly one service.
REQ-028 Wait counter SHALL clear on entering WRITEBACK/REFILL and increment each cycle without ack.
REQ-029 If the wait counter reaches TIMEOUT, SHALL drop o_mem_req, set o_error, and enter ERROR.
REQ-030 ERROR SHALL be left only by reset.
REQ-031 o_busy SHALL be 1 in every state except IDLE.
REQ-032 o_miss_cnt SHALL increment on each REFILL ack; o_wb_cnt SHALL increment on each WRITEBACK ack.
REQ-033 o_miss_cnt and o_wb_cnt SHALL saturate at 16'hFFFF.
REQ-034 Outputs other than o_mem_* SHALL be registered.

Reset
REQ-035 On rst=0, SHALL immediately clear the state to IDLE, all outputs, counters and latches to 0, and set armed=1.
REQ-036 On reset during WRITEBACK/REFILL, o_mem_req SHALL drop asynchronously, with no response pulse.

Structure
REQ-037 State encoding and default widths (tag 18, index 8, offset 6) SHALL live in shared package sa_cache_pkg, used also by sa_cache.
REQ-038 The request-wait timer SHALL be sub-module sa_cache_req_timer (clear, count, expired).

Verification
REQ-039 Clean miss: miss=1, addr=32'h0001_2345, evict=0; ack after 3 cycles, rdata=32'hDEADBEEF -> request addr 32'h0001_2340 (we=0); one response pulse with line DEADBEEF; miss_cnt=1.
REQ-040 Dirty miss: evict=1, evict_addr=32'h0000_8040, evict_data=32'hCAFEF00D -> write at 8040, then read, then response; wb_cnt=1, miss_cnt=1.
REQ-041 Ack in the same cycle as req: ack=1 on the first REFILL cycle -> RESPOND next cycle; total miss-to-response latency 3 cycles.
REQ-042 Miss held high across response for 2 extra cycles -> no second request until miss goes low then high again.
REQ-043 TIMEOUT=8 with ack never asserted -> req drops after 8 wait cycles, o_error=1, stuck until rst=0.
REQ-044 rst=0 mid-REFILL -> o_mem_req=0 before the next edge; no response; counters=0.
